// File: rtl/line_burst_adaptor.sv
// ---------------------------------------------------------------------------
// line_burst_adaptor
//
// Bridges the cache's 256-bit line interface to a 64-bit burst memory port.
// One line fill or writeback from the cache becomes four 64-bit memory beats.
// The cache gets a single-cycle completion pulse when the line transfer is done.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   address_i  : cache request address (only the line-aligned bits are used)
//   read_i     : cache line fill request
//   write_i    : cache line writeback request (wins over read_i)
//   line_i     : line to write back
//   line_o     : assembled fill line
//   resp_o     : one-cycle completion pulse to the cache
//   address_o  : line-aligned memory address (low 5 bits always 0)
//   read_o     : memory burst read
//   write_o    : memory burst write
//   burst_o    : current write beat
//   burst_i    : current read beat
//   resp_i     : memory beat strobe; one beat is transferred per cycle it is high
//
// Build option
//   LINE_BURST_ADAPTOR_EARLY_RESP_EN : the read path skips DONE. resp_o fires
//   together with the 4th read strobe, and the last beat is forwarded
//   combinationally into the top of line_o. If the macro is undefined, resp_o
//   and line_o come only from registers.
// ---------------------------------------------------------------------------
module line_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beatCnt_q, beatCnt_d;
    logic [LINE_W-1:0]   lineBuf_q, lineBuf_d;
    logic [ADDR_W-6:0]   addrReg_q, addrReg_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                resp_q, resp_d;
    logic                lastBeat;

    // The offset bits inside a line never reach memory.
    logic                unusedAddrLsbs;
    assign unusedAddrLsbs = ^address_i[4:0];

    assign lastBeat = (beatCnt_q == CNT_W'(BEATS - 1));

    // Next-state logic. Requests are only looked at in IDLE. Beats advance on
    // resp_i strobes only, so memory can stall for any number of cycles.
    // The read_o/write_o/resp_o flops are loaded from the next state. This makes
    // them rise one cycle after the request and drop while in DONE.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        lineBuf_d = lineBuf_q;
        addrReg_d = addrReg_q;

        case (state_q)
            IDLE: begin
                if (write_i) begin
                    lineBuf_d = line_i;
                    addrReg_d = address_i[ADDR_W-1:5];
                    beatCnt_d = '0;
                    state_d   = WR_BURST;
                end else if (read_i) begin
                    addrReg_d = address_i[ADDR_W-1:5];
                    beatCnt_d = '0;
                    state_d   = RD_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    lineBuf_d[int'(beatCnt_q)*BURST_W +: BURST_W] = burst_i;
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (lastBeat) begin
`ifdef LINE_BURST_ADAPTOR_EARLY_RESP_EN
                        state_d = IDLE;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (lastBeat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        read_d  = (state_d == RD_BURST);
        write_d = (state_d == WR_BURST);
        resp_d  = (state_d == DONE);
    end

    // FSM and datapath registers. Reset clears everything, so a reset in the
    // middle of a burst drops read_o/write_o immediately and throws away the
    // partly filled line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            lineBuf_q <= '0;
            addrReg_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            lineBuf_q <= lineBuf_d;
            addrReg_q <= addrReg_d;
            read_q    <= read_d;
            write_q   <= write_d;
            resp_q    <= resp_d;
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign address_o = {addrReg_q, 5'b0};

    // burst_o is only non-zero while a writeback burst is running.
    assign burst_o = write_q ? lineBuf_q[int'(beatCnt_q)*BURST_W +: BURST_W]
                             : '0;

`ifdef LINE_BURST_ADAPTOR_EARLY_RESP_EN
    // Completion is signalled together with the 4th read strobe. The beat is
    // still on burst_i in that cycle, so it is forwarded into the top slice.
    logic earlyResp;
    assign earlyResp = (state_q == RD_BURST) && resp_i && lastBeat;
    assign resp_o    = resp_q | earlyResp;

    always_comb begin
        line_o = lineBuf_q;
        if (earlyResp) begin
            line_o[LINE_W-1 -: BURST_W] = burst_i;
        end
    end
`else
    assign resp_o = resp_q;
    assign line_o = lineBuf_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// ---------------------------------------------------------------------------
// tb_line_burst_adaptor
//
// Directed test for line_burst_adaptor. There is one vector per clock cycle.
// Inputs are driven just after the rising edge. Outputs are sampled on the
// falling edge. A few hand-written sequences cover asynchronous reset during
// a burst and a fresh read after it.
// ---------------------------------------------------------------------------
module tb_line_burst_adaptor;

`ifdef LINE_BURST_ADAPTOR_EARLY_RESP_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [31:0]   address_i;
   logic          read_i;
   logic          write_i;
   logic [255:0]  line_i;
   logic [255:0]  line_o;
   logic          resp_o;
   logic [31:0]   address_o;
   logic          read_o;
   logic          write_o;
   logic [63:0]   burst_o;
   logic [63:0]   burst_i;
   logic          resp_i;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [31:0]   addr;
      logic [255:0]  lineIn;
      logic          rsp;
      logic [63:0]   burstIn;
      logic          expRd;
      logic          expWr;
      logic          expResp;
      logic [31:0]   expAddr;
      logic [63:0]   expBurst;
      logic          chkLine;
      logic [255:0]  expLine;
   } vec_t;

   vec_t vecs[$];

   line_burst_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .resp_o    (resp_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .burst_o   (burst_o),
      .burst_i   (burst_i),
      .resp_i    (resp_i)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value, count it, and report it if it is wrong.
   task automatic checkField(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Check all DUT outputs against one vector's expected values.
   task automatic checkOutput(input vec_t v, input int idx);
      checkField($sformatf("v%0d.read_o", idx),    256'(read_o),    256'(v.expRd));
      checkField($sformatf("v%0d.write_o", idx),   256'(write_o),   256'(v.expWr));
      checkField($sformatf("v%0d.resp_o", idx),    256'(resp_o),    256'(v.expResp));
      checkField($sformatf("v%0d.address_o", idx), 256'(address_o), 256'(v.expAddr));
      checkField($sformatf("v%0d.burst_o", idx),   256'(burst_o),   256'(v.expBurst));
      if (v.chkLine)
         checkField($sformatf("v%0d.line_o", idx), line_o, v.expLine);
   endtask

   // Drive one vector, sample on the falling edge, then move to just after
   // the next rising edge.
   task automatic applyStimulus(input vec_t v, input int idx);
      read_i    = v.rd;
      write_i   = v.wr;
      address_i = v.addr;
      line_i    = v.lineIn;
      resp_i    = v.rsp;
      burst_i   = v.burstIn;
      @(negedge clk);
      checkOutput(v, idx);
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] lineIn, input logic rsp,
                         input logic [63:0] burstIn, input logic expRd,
                         input logic expWr, input logic expResp,
                         input logic [31:0] expAddr, input logic [63:0] expBurst,
                         input logic chkLine, input logic [255:0] expLine);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.lineIn = lineIn; v.rsp = rsp;
      v.burstIn = burstIn; v.expRd = expRd; v.expWr = expWr; v.expResp = expResp;
      v.expAddr = expAddr; v.expBurst = expBurst; v.chkLine = chkLine;
      v.expLine = expLine;
      vecs.push_back(v);
   endtask

   // Main sequence: reset checks, the vector table, then the hand-written
   // reset-abort and fresh-read sequences.
   initial begin
      logic [63:0]  b11, b22, b33, b44, bAA, bBB, bCC, bDD, bJunk;
      logic [63:0]  s1, s2, s3, s4, m5, m6, m7, m8;
      logic [255:0] lineRd1, lineWr1, lineRd2, lineSim, lineZero, freshLine;
      logic [63:0]  fresh [4];
      logic         respPat [7];
      logic [63:0]  patData [7];
      bit           seen;
      int           beat;
      int           respCycle;

      b11 = {16{4'h1}}; b22 = {16{4'h2}}; b33 = {16{4'h3}}; b44 = {16{4'h4}};
      bAA = {16{4'hA}}; bBB = {16{4'hB}}; bCC = {16{4'hC}}; bDD = {16{4'hD}};
      bJunk = 64'hDEAD_BEEF_DEAD_BEEF;
      s1 = {8{8'h01}}; s2 = {8{8'h02}}; s3 = {8{8'h03}}; s4 = {8{8'h04}};
      m5 = {16{4'h5}}; m6 = {16{4'h6}}; m7 = {16{4'h7}}; m8 = {16{4'h8}};
      lineRd1  = {b44, b33, b22, b11};
      lineWr1  = {bDD, bCC, bBB, bAA};
      lineRd2  = {s4, s3, s2, s1};
      lineSim  = {m8, m7, m6, m5};
      lineZero = '0;

      rst = 1'b1; read_i = 0; write_i = 0; address_i = '0; line_i = '0;
      resp_i = 0; burst_i = '0;

      #3;
      checkField("rst.read_o",    256'(read_o),    256'(0));
      checkField("rst.write_o",   256'(write_o),   256'(0));
      checkField("rst.resp_o",    256'(resp_o),    256'(0));
      checkField("rst.address_o", 256'(address_o), 256'(0));
      checkField("rst.burst_o",   256'(burst_o),   256'(0));
      checkField("rst.line_o",    line_o,          lineZero);

      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Read fill at 0x1234: four back-to-back beats, resp_o in cycle 6.
      addVec(1,0,32'h0000_1234,'0,0,'0,         0,0,0,        32'h0,'0,1,lineZero);
      addVec(1,0,32'h0000_1234,'0,1,b11,        1,0,0,        32'h0000_1220,'0,0,'0);
      addVec(1,0,32'h0000_1234,'0,1,b22,        1,0,0,        32'h0000_1220,'0,0,'0);
      addVec(1,0,32'h0000_1234,'0,1,b33,        1,0,0,        32'h0000_1220,'0,0,'0);
      addVec(1,0,32'h0000_1234,'0,1,b44,        1,0,EARLY,    32'h0000_1220,'0,EARLY,lineRd1);
      addVec(0,0,32'h0,'0,0,'0,                 0,0,!EARLY,   32'h0000_1220,'0,1,lineRd1);
      addVec(0,0,32'h0,'0,0,'0,                 0,0,0,        32'h0000_1220,'0,1,lineRd1);
      // Writeback at 0x8000_00E0. AA is sent first, and write_o is low in DONE.
      addVec(0,1,32'h8000_00E0,lineWr1,0,'0,    0,0,0,        32'h0000_1220,'0,1,lineRd1);
      addVec(0,1,32'h8000_00E0,lineWr1,1,'0,    0,1,0,        32'h8000_00E0,bAA,0,'0);
      addVec(0,1,32'h8000_00E0,lineWr1,1,'0,    0,1,0,        32'h8000_00E0,bBB,0,'0);
      addVec(0,1,32'h8000_00E0,lineWr1,1,'0,    0,1,0,        32'h8000_00E0,bCC,0,'0);
      addVec(0,1,32'h8000_00E0,lineWr1,1,'0,    0,1,0,        32'h8000_00E0,bDD,0,'0);
      addVec(0,1,32'h8000_00E0,lineWr1,0,'0,    0,0,1,        32'h8000_00E0,'0,0,'0);
      addVec(0,0,32'h0,'0,0,'0,                 0,0,0,        32'h8000_00E0,'0,0,'0);
      // Stalled read. resp_i pattern is 1,0,0,1,0,1,1. Junk on burst_i in
      // the gap cycles must not be captured.
      addVec(1,0,32'h0000_0040,'0,0,'0,         0,0,0,        32'h8000_00E0,'0,0,'0);
      respPat = '{1,0,0,1,0,1,1};
      patData = '{s1,bJunk,bJunk,s2,bJunk,s3,s4};
      for (int i = 0; i < 7; i++) begin
         addVec(1,0,32'h0000_0040,'0,respPat[i],patData[i],
                1,0,(i == 6) ? EARLY : 1'b0,32'h0000_0040,'0,
                (i == 6) ? EARLY : 1'b0,lineRd2);
      end
      // resp_i in DONE and in IDLE is ignored.
      addVec(0,0,32'h0,'0,1,bJunk,              0,0,!EARLY,   32'h0000_0040,'0,1,lineRd2);
      addVec(0,0,32'h0,'0,1,bJunk,              0,0,0,        32'h0000_0040,'0,1,lineRd2);
      addVec(0,0,32'h0,'0,0,'0,                 0,0,0,        32'h0000_0040,'0,1,lineRd2);
      // With read and write requested together, the write wins: read_o
      // stays low and line_i is sent.
      addVec(1,1,32'h0000_1000,lineSim,0,'0,    0,0,0,        32'h0000_0040,'0,0,'0);
      addVec(1,1,32'h0000_1000,lineSim,1,'0,    0,1,0,        32'h0000_1000,m5,0,'0);
      addVec(1,1,32'h0000_1000,lineSim,1,'0,    0,1,0,        32'h0000_1000,m6,0,'0);
      addVec(1,1,32'h0000_1000,lineSim,1,'0,    0,1,0,        32'h0000_1000,m7,0,'0);
      addVec(1,1,32'h0000_1000,lineSim,1,'0,    0,1,0,        32'h0000_1000,m8,0,'0);
      addVec(1,1,32'h0000_1000,lineSim,0,'0,    0,0,1,        32'h0000_1000,'0,0,'0);
      addVec(0,0,32'h0,'0,0,'0,                 0,0,0,        32'h0000_1000,'0,0,'0);

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Assert reset asynchronously after two beats of a read.
      read_i = 1; address_i = 32'h0000_2000; resp_i = 0;
      @(posedge clk); #1;
      resp_i = 1; burst_i = 64'hAAAA_0001_AAAA_0001;
      @(posedge clk); #1;
      burst_i = 64'hAAAA_0002_AAAA_0002;
      @(posedge clk); #1;
      resp_i = 0; burst_i = '0;
      @(negedge clk);
      checkField("abort.pre.read_o", 256'(read_o), 256'(1));
      #2;
      rst = 1'b1;
      #1;
      checkField("abort.read_o",    256'(read_o),    256'(0));
      checkField("abort.write_o",   256'(write_o),   256'(0));
      checkField("abort.resp_o",    256'(resp_o),    256'(0));
      checkField("abort.address_o", 256'(address_o), 256'(0));
      checkField("abort.burst_o",   256'(burst_o),   256'(0));
      checkField("abort.line_o",    line_o,          lineZero);
      read_i = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkField($sformatf("abort.noresp%0d", i), 256'(resp_o), 256'(0));
      end
      @(posedge clk); #1;

      // A fresh read after the abort completes with new data only. Waiting
      // for resp_o is limited to a fixed number of cycles.
      fresh = '{64'h9A9A_0000_0000_0001, 64'h9A9A_0000_0000_0002,
                64'h9A9A_0000_0000_0003, 64'h9A9A_0000_0000_0004};
      freshLine = {fresh[3], fresh[2], fresh[1], fresh[0]};
      read_i = 1; address_i = 32'h0000_3064; resp_i = 0;
      @(posedge clk); #1;
      seen = 0; beat = 0; respCycle = -1;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (beat < 4) begin
            resp_i = 1; burst_i = fresh[beat];
         end else begin
            resp_i = 0; burst_i = '0;
         end
         @(negedge clk);
         if (resp_o) begin
            seen = 1;
            respCycle = c;
            checkField("fresh.line_o",    line_o,          freshLine);
            checkField("fresh.address_o", 256'(address_o), 256'(32'h0000_3060));
         end
         @(posedge clk); #1;
         if (resp_i) beat++;
      end
      read_i = 0; resp_i = 0; burst_i = '0;
      if (!seen) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL fresh.resp_timeout: got no resp_o, expected resp_o within 12 cycles");
      end else begin
         checkField("fresh.latency", 256'(respCycle), EARLY ? 256'(3) : 256'(4));
      end
      @(negedge clk);
      checkField("fresh.idle.resp_o", 256'(resp_o), 256'(0));
      checkField("fresh.idle.line_o", line_o,       freshLine);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
